// File: rtl/dram_if_pkg.sv
// Shared types and helpers for the cache-side DRAM miss/writeback path.
package dram_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD,
    CAP,
    RESP
  } miss_state_t;

  localparam logic LSU_LW = 1'b0;
  localparam logic LSU_SW = 1'b1;

  // Packs {valid=1, tag, data} LSB-aligned; the caller truncates to TAG+DATA+1 bits.
  function automatic logic [127:0] pack_wdata(input logic [63:0] tag,
                                              input logic [63:0] data,
                                              input int          tag_w,
                                              input int          data_w);
    return (128'(1) << (tag_w + data_w)) | (128'(tag) << data_w) | 128'(data);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dram_miss_handler.sv
// Single-outstanding miss handler: optional victim writeback, then one read
// whose registered result is returned to the cache with a valid/ready fill.
module dram_miss_handler
  import dram_if_pkg::*;
#(
  parameter int TAG   = 20,
  parameter int DATA  = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [31:0]         miss_addr,
  input  logic                victim_dirty,
  input  logic [31:0]         victim_addr,
  input  logic [TAG-1:0]      victim_tag,
  input  logic [DATA-1:0]     victim_data,
  output logic                fill_valid,
  input  logic                fill_ready,
  output logic [31:0]         fill_addr,
  output logic [DATA-1:0]     fill_data,
  output logic [31:0]         address,
  output logic                lsu_operator,
  output logic                mem_req,
  output logic [TAG+DATA:0]   write_data_int,
  input  logic                mem_ready,
  input  logic [DATA-1:0]     dram_data_out,
  output logic [CNT_W-1:0]    miss_count,
  output logic [CNT_W-1:0]    wb_count
);

  localparam int WD_W = TAG + DATA + 1;

  miss_state_t     r_state;
  miss_state_t     w_state_next;
  logic [31:0]     r_miss_addr;
  logic [31:0]     r_victim_addr;
  logic            r_victim_dirty;
  logic [TAG-1:0]  r_victim_tag;
  logic [DATA-1:0] r_victim_data;
  logic [DATA-1:0] r_fill_data;
  logic [WD_W-1:0] w_wdata;
  logic            w_accept;
  logic            w_wb_done;

  assign w_accept  = (r_state == IDLE) && miss_valid;
  assign w_wb_done = (r_state == WB) && r_victim_dirty && mem_ready;
  assign w_wdata   = WD_W'(pack_wdata(64'(r_victim_tag), 64'(r_victim_data), TAG, DATA));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DRAM-side outputs depend only on state and latched copies, never on miss_* inputs.
  always_comb begin
    w_state_next   = r_state;
    miss_ready     = 1'b0;
    fill_valid     = 1'b0;
    mem_req        = 1'b0;
    lsu_operator   = LSU_LW;
    address        = '0;
    write_data_int = '0;
    case (r_state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          w_state_next = victim_dirty ? WB : RD;
        end
      end
      WB: begin
        mem_req        = 1'b1;
        lsu_operator   = LSU_SW;
        address        = r_victim_addr;
        write_data_int = w_wdata;
        if (mem_ready) begin
          w_state_next = RD;
        end
      end
      RD: begin
        mem_req = 1'b1;
        address = r_miss_addr;
        if (mem_ready) begin
          w_state_next = CAP;
        end
      end
      CAP: begin
        w_state_next = RESP;
      end
      RESP: begin
        fill_valid = 1'b1;
        if (fill_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_addr    <= '0;
      r_victim_addr  <= '0;
      r_victim_dirty <= 1'b0;
      r_victim_tag   <= '0;
      r_victim_data  <= '0;
      r_fill_data    <= '0;
    end else begin
      if (w_accept) begin
        r_miss_addr    <= miss_addr;
        r_victim_addr  <= victim_addr;
        r_victim_dirty <= victim_dirty;
        r_victim_tag   <= victim_tag;
        r_victim_data  <= victim_data;
      end
      // DRAM read data is valid exactly one cycle after the accepted read.
      if (r_state == CAP) begin
        r_fill_data <= dram_data_out;
      end
    end
  end

  assign fill_addr = r_miss_addr;
  assign fill_data = r_fill_data;

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_accept),
    .o_count (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_wb_done),
    .o_count (wb_count)
  );

endmodule
